// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding,
// abort counter width and default timing constants.
package bridge_arb_pkg;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ENC_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ENC_SEND = 2'd1;
    localparam logic [STATE_W-1:0] ENC_GAP  = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = ENC_IDLE,
        SEND = ENC_SEND,
        GAP  = ENC_GAP
    } arb_state_e;

    localparam int ABORT_CNT_W = 8;

    localparam int DEFAULT_NREQ          = 3;
    localparam int DEFAULT_GAP_CYCLES    = 16;
    localparam int DEFAULT_STALL_TIMEOUT = 4800;

    function automatic logic [ABORT_CNT_W-1:0] sat_inc(input logic [ABORT_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART bundle for the arbiter; master is the arbiter side,
// slave is the requesters plus uart_tx.
interface uart_tx_arbiter_if #(
    parameter int NREQ = bridge_arb_pkg::DEFAULT_NREQ
);
    import bridge_arb_pkg::*;

    logic [8*NREQ-1:0]      req_data;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_urgent;
    logic [NREQ-1:0]        req_ready;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic                   abort_pulse;
    logic [ABORT_CNT_W-1:0] abort_cnt;

    modport master (
        input  req_data, req_valid, req_last, req_urgent, tx_ready,
        output req_ready, tx_data, tx_valid, grant, busy, abort_pulse, abort_cnt
    );

    modport slave (
        output req_data, req_valid, req_last, req_urgent, tx_ready,
        input  req_ready, tx_data, tx_valid, grant, busy, abort_pulse, abort_cnt
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational picker: lowest-index urgent requester wins, otherwise the
// first valid requester scanning upward from ptr+1 with wraparound.
module rr_pick import bridge_arb_pkg::*; #(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [NREQ-1:0] urgent,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] winner,
    output logic [IDXW-1:0] winner_idx,
    output logic            any
);

    logic found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        any        = |valid;

        for (int i = 0; i < NREQ; i++) begin
            if (!found && valid[i] && urgent[i]) begin
                found      = 1'b1;
                winner[i]  = 1'b1;
                winner_idx = IDXW'(i);
            end
        end

        // Step k visits requester (ptr+k) mod NREQ, so ptr itself is tried last.
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && valid[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                    found      = 1'b1;
                    winner[i]  = 1'b1;
                    winner_idx = IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic arbiter sharing one uart_tx byte channel among NREQ
// requesters, with urgent override, stall watchdog and inter-packet gap.
module uart_tx_arbiter import bridge_arb_pkg::*; #(
    parameter int NREQ          = DEFAULT_NREQ,
    parameter int GAP_CYCLES    = DEFAULT_GAP_CYCLES,
    parameter int STALL_TIMEOUT = DEFAULT_STALL_TIMEOUT
) (
    input  logic              CLK,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);

    localparam int IDXW   = $clog2(NREQ);
    localparam int GAPW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int STALLW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [GAPW-1:0]   GAP_LAST   = GAPW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [STALLW-1:0] STALL_LAST = STALLW'(STALL_TIMEOUT - 1);
    localparam arb_state_e        POST_PKT   = (GAP_CYCLES > 0) ? GAP : IDLE;

    arb_state_e             state_q, state_d;
    logic [NREQ-1:0]        grant_q, grant_d;
    logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [GAPW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [STALLW-1:0]      stall_cnt_q, stall_cnt_d;
    logic [ABORT_CNT_W-1:0] abort_cnt_q, abort_cnt_d;
    logic                   abort_pulse_q, abort_pulse_d;

    logic [NREQ-1:0] pick_winner;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            urgent_win;
    logic            in_send;
    logic            g_valid;
    logic            g_last;
    logic [7:0]      g_data;
    logic            accept;
    logic            pkt_done;
    logic            stall_hit;

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .valid      (bus.req_valid),
        .urgent     (bus.req_urgent),
        .ptr        (rr_ptr_q),
        .winner     (pick_winner),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // grant_q is zero outside SEND, so these selects are inert when idle.
    always_comb begin
        g_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) g_data = bus.req_data[8*i +: 8];
        end
    end

    assign urgent_win = |(bus.req_urgent & bus.req_valid);
    assign in_send    = (state_q == SEND);
    assign g_valid    = |(bus.req_valid & grant_q);
    assign g_last     = |(bus.req_valid & bus.req_last & grant_q);
    assign accept     = in_send & g_valid & bus.tx_ready;
    assign pkt_done   = accept & g_last;
    assign stall_hit  = in_send & ~g_valid & (stall_cnt_q == STALL_LAST);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= IDXW'(NREQ - 1);
            gap_cnt_q     <= '0;
            stall_cnt_q   <= '0;
            abort_cnt_q   <= '0;
            abort_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            gap_cnt_q     <= gap_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            abort_cnt_q   <= abort_cnt_d;
            abort_pulse_q <= abort_pulse_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        gap_cnt_d     = gap_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        abort_cnt_d   = abort_cnt_q;
        abort_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                gap_cnt_d   = '0;
                stall_cnt_d = '0;
                if (pick_any) begin
                    grant_d = pick_winner;
                    state_d = SEND;
                    if (!urgent_win) rr_ptr_d = pick_idx;
                end
            end
            SEND: begin
                if (accept)        stall_cnt_d = '0;
                else if (!g_valid) stall_cnt_d = stall_cnt_q + 1'b1;

                if (pkt_done) begin
                    grant_d = '0;
                    state_d = POST_PKT;
                end else if (stall_hit) begin
                    grant_d       = '0;
                    abort_pulse_d = 1'b1;
                    abort_cnt_d   = sat_inc(abort_cnt_q);
                    state_d       = POST_PKT;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.tx_data     = in_send ? g_data : 8'h00;
        bus.tx_valid    = in_send & g_valid;
        bus.req_ready   = in_send ? (grant_q & {NREQ{bus.tx_ready}}) : '0;
        bus.grant       = grant_q;
        bus.busy        = (state_q != IDLE);
        bus.abort_pulse = abort_pulse_q;
        bus.abort_cnt   = abort_cnt_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester models feed the DUT and
// a scoreboard of expected (owner, byte) pairs is checked at every UART accept.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 3;
    localparam int GAP   = 4;
    localparam int STALL = 20;

    typedef struct packed {
        logic [2:0] gnt;
        logic [7:0] data;
    } sb_t;

    logic CLK = 1'b0;
    logic rst_n;
    always #5 CLK = ~CLK;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NREQ          (NREQ),
        .GAP_CYCLES    (GAP),
        .STALL_TIMEOUT (STALL)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    sb_t        sbq[$];
    int         accCyc[$];
    logic [2:0] acc;
    int         cyc = 0;
    bit         throttle;
    int         total = 0;
    int         passed = 0;
    int         failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveReqs();
        logic [23:0] d;
        logic [2:0]  v;
        logic [2:0]  l;
        d = '0; v = '0; l = '0;
        if (q0.size() > 0) begin v[0] = 1'b1; d[7:0]   = q0[0][7:0]; l[0] = q0[0][8]; end
        if (q1.size() > 0) begin v[1] = 1'b1; d[15:8]  = q1[0][7:0]; l[1] = q1[0][8]; end
        if (q2.size() > 0) begin v[2] = 1'b1; d[23:16] = q2[0][7:0]; l[2] = q2[0][8]; end
        bus.req_data  = d;
        bus.req_valid = v;
        bus.req_last  = l;
    endtask

    task automatic applyStimulus(input int i, input int n, input logic [7:0] base, input bit endPkt);
        logic [7:0] b;
        logic       l;
        for (int k = 0; k < n; k++) begin
            b = base + 8'(k);
            l = endPkt && (k == n - 1);
            case (i)
                0:       q0.push_back({l, b});
                1:       q1.push_back({l, b});
                default: q2.push_back({l, b});
            endcase
        end
        driveReqs();
    endtask

    task automatic expectPacket(input int i, input int n, input logic [7:0] base);
        sb_t e;
        for (int k = 0; k < n; k++) begin
            e.gnt  = 3'(1 << i);
            e.data = base + 8'(k);
            sbq.push_back(e);
        end
    endtask

    task automatic flushAll();
        q0.delete(); q1.delete(); q2.delete();
        sbq.delete();
        acc = '0;
        driveReqs();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        flushAll();
        repeat (2) @(posedge CLK);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge CLK);
            done = (sbq.size() == 0) && (q0.size() == 0) && (q1.size() == 0)
                   && (q2.size() == 0) && !bus.busy;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Requester models retire a byte one step after its handshake was seen.
    always @(negedge CLK) acc = rst_n ? (bus.req_ready & bus.req_valid) : 3'b000;

    always @(posedge CLK) begin
        #1;
        if (acc[0] && q0.size() > 0) void'(q0.pop_front());
        if (acc[1] && q1.size() > 0) void'(q1.pop_front());
        if (acc[2] && q2.size() > 0) void'(q2.pop_front());
        acc = '0;
        driveReqs();
        bus.tx_ready = throttle ? (cyc % 4 == 0) : 1'b1;
    end

    always @(negedge CLK) begin
        sb_t e;
        if (rst_n && bus.tx_valid && bus.tx_ready) begin
            checkOutput("sb_has_entry", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput("tx_data", 32'(bus.tx_data), 32'(e.data));
                checkOutput("tx_owner", 32'(bus.grant), 32'(e.gnt));
                accCyc.push_back(cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit found;
        int n;
        int mirrors;

        rst_n          = 1'b1;
        throttle       = 1'b0;
        bus.tx_ready   = 1'b1;
        bus.req_urgent = 3'b000;
        flushAll();
        #1;
        doReset();

        $display("[TB] reset values");
        checkOutput("rst_grant",       32'(bus.grant),       32'd0);
        checkOutput("rst_busy",        32'(bus.busy),        32'd0);
        checkOutput("rst_tx_valid",    32'(bus.tx_valid),    32'd0);
        checkOutput("rst_tx_data",     32'(bus.tx_data),     32'd0);
        checkOutput("rst_req_ready",   32'(bus.req_ready),   32'd0);
        checkOutput("rst_abort_pulse", 32'(bus.abort_pulse), 32'd0);
        checkOutput("rst_abort_cnt",   32'(bus.abort_cnt),   32'd0);

        $display("[TB] single 3-byte packet from requester 1");
        accCyc.delete();
        @(posedge CLK); #2;
        applyStimulus(1, 3, 8'hA1, 1'b1);
        expectPacket(1, 3, 8'hA1);
        @(negedge CLK);
        checkOutput("t1_latency_grant", 32'(bus.grant), 32'd0);
        @(negedge CLK);
        checkOutput("t1_grant", 32'(bus.grant), 32'b010);
        checkOutput("t1_first_valid", 32'(bus.tx_valid), 32'd1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (bus.req_valid[1] && bus.req_last[1] && bus.req_ready[1]) found = 1'b1;
            else @(negedge CLK);
        end
        checkOutput("t1_last_seen", 32'(found), 32'd1);
        for (int k = 0; k < GAP; k++) begin
            @(negedge CLK);
            checkOutput("t1_gap_busy", 32'(bus.busy), 32'd1);
            checkOutput("t1_gap_tx_valid", 32'(bus.tx_valid), 32'd0);
            checkOutput("t1_gap_grant", 32'(bus.grant), 32'd0);
        end
        @(negedge CLK);
        checkOutput("t1_idle_after_gap", 32'(bus.busy), 32'd0);
        checkOutput("t1_byte_count", 32'(accCyc.size()), 32'd3);
        if (accCyc.size() == 3) begin
            checkOutput("t1_b2_consecutive", 32'(accCyc[1] - accCyc[0]), 32'd1);
            checkOutput("t1_b3_consecutive", 32'(accCyc[2] - accCyc[1]), 32'd1);
        end

        $display("[TB] round robin across three busy requesters");
        doReset();
        @(posedge CLK); #2;
        applyStimulus(2, 2, 8'h20, 1'b1);
        applyStimulus(2, 2, 8'h22, 1'b1);
        applyStimulus(1, 2, 8'h10, 1'b1);
        applyStimulus(1, 2, 8'h12, 1'b1);
        applyStimulus(0, 2, 8'h00, 1'b1);
        applyStimulus(0, 2, 8'h02, 1'b1);
        expectPacket(0, 2, 8'h00);
        expectPacket(1, 2, 8'h10);
        expectPacket(2, 2, 8'h20);
        expectPacket(0, 2, 8'h02);
        expectPacket(1, 2, 8'h12);
        expectPacket(2, 2, 8'h22);
        waitDrain(200, "t2_drain");
        checkOutput("t2_no_abort", 32'(bus.abort_cnt), 32'd0);

        $display("[TB] urgent request waits for packet end");
        doReset();
        @(posedge CLK); #2;
        applyStimulus(1, 4, 8'h30, 1'b1);
        expectPacket(1, 4, 8'h30);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge CLK);
            found = (bus.grant == 3'b010);
        end
        checkOutput("t3_req1_granted", 32'(found), 32'd1);
        @(posedge CLK); #2;
        bus.req_urgent = 3'b001;
        applyStimulus(2, 2, 8'h50, 1'b1);
        applyStimulus(0, 2, 8'h40, 1'b1);
        expectPacket(0, 2, 8'h40);
        expectPacket(2, 2, 8'h50);
        waitDrain(100, "t3_drain");
        bus.req_urgent = 3'b000;

        $display("[TB] stall watchdog abort");
        doReset();
        @(posedge CLK); #2;
        applyStimulus(2, 1, 8'hC0, 1'b0);
        expectPacket(2, 1, 8'hC0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge CLK);
            found = bus.req_ready[2] && bus.req_valid[2];
        end
        checkOutput("t4_byte_accepted", 32'(found), 32'd1);
        n = 0;
        found = 1'b0;
        while (n < 60 && !found) begin
            @(negedge CLK);
            n++;
            found = bus.abort_pulse;
        end
        checkOutput("t4_abort_delay", 32'(n), 32'd21);
        checkOutput("t4_abort_grant", 32'(bus.grant), 32'd0);
        checkOutput("t4_abort_cnt", 32'(bus.abort_cnt), 32'd1);
        checkOutput("t4_abort_busy", 32'(bus.busy), 32'd1);
        n = 0;
        found = 1'b0;
        while (n < 20 && !found) begin
            @(negedge CLK);
            n++;
            if (n == 1) checkOutput("t4_pulse_one_cycle", 32'(bus.abort_pulse), 32'd0);
            found = !bus.busy;
        end
        checkOutput("t4_gap_len", 32'(n), 32'd4);
        waitDrain(10, "t4_drain");

        $display("[TB] throttled uart_tx ready");
        doReset();
        throttle = 1'b1;
        @(posedge CLK); #2;
        applyStimulus(0, 5, 8'h60, 1'b1);
        expectPacket(0, 5, 8'h60);
        mirrors = 0;
        found = 1'b0;
        for (int k = 0; k < 120 && !found; k++) begin
            @(negedge CLK);
            if (bus.grant == 3'b001) begin
                checkOutput("t5_ready_mirror", 32'(bus.req_ready), {29'd0, 2'b00, bus.tx_ready});
                mirrors++;
            end
            found = (sbq.size() == 0) && (q0.size() == 0) && !bus.busy;
        end
        checkOutput("t5_drain", 32'(found), 32'd1);
        checkOutput("t5_mirror_seen", 32'(mirrors >= 5), 32'd1);
        checkOutput("t5_no_abort", 32'(bus.abort_cnt), 32'd0);
        throttle = 1'b0;

        $display("[TB] asynchronous reset mid-packet");
        doReset();
        @(posedge CLK); #2;
        applyStimulus(1, 5, 8'h70, 1'b1);
        expectPacket(1, 5, 8'h70);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge CLK);
            found = bus.tx_valid && (bus.tx_data == 8'h71);
        end
        checkOutput("t6_byte2_offered", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_tx_valid",  32'(bus.tx_valid),  32'd0);
        checkOutput("t6_rst_tx_data",   32'(bus.tx_data),   32'd0);
        checkOutput("t6_rst_grant",     32'(bus.grant),     32'd0);
        checkOutput("t6_rst_busy",      32'(bus.busy),      32'd0);
        checkOutput("t6_rst_req_ready", 32'(bus.req_ready), 32'd0);
        doReset();
        @(posedge CLK); #2;
        applyStimulus(1, 2, 8'h80, 1'b1);
        applyStimulus(0, 2, 8'h90, 1'b1);
        expectPacket(0, 2, 8'h90);
        expectPacket(1, 2, 8'h80);
        waitDrain(100, "t6_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
